// File: rtl/mux8_4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux8_4_pkg
//  Description : Shared lane geometry defaults and select-width derivation.
//  Revision    : 1.0
// ============================================================================
package mux8_4_pkg;

    localparam int C_LANE_W_DEF = 4;
    localparam int C_LANES_DEF  = 8;

    // A single lane still needs a one-bit select port.
    function automatic int sel_width(input int lanes);
        int w;
        w = 0;
        while ((1 << w) < lanes) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    localparam int C_SEL_W_DEF = sel_width(C_LANES_DEF);

endpackage : mux8_4_pkg
`default_nettype wire

// File: rtl/mux8_4_sel.sv
`default_nettype none
// ============================================================================
//  Module      : mux8_4_sel
//  Description : Combinational lane selector; an out-of-range select yields zero.
//  Revision    : 1.0
// ============================================================================
module mux8_4_sel
    import mux8_4_pkg::*;
#(
    parameter int LANE_W = C_LANE_W_DEF,
    parameter int LANES  = C_LANES_DEF,
    parameter int SEL_W  = sel_width(LANES)
) (
    input  logic [SEL_W-1:0]        select_i,
    input  logic [LANES*LANE_W-1:0] in_i,
    output logic [LANE_W-1:0]       lane_o
);

    // Only indices that match a real lane drive the output, so select >= LANES
    // falls through to the all-zero default.
    always_comb begin
        lane_o = '0;
        for (int k = 0; k < LANES; k++) begin
            if (select_i == SEL_W'(k)) begin
                lane_o = in_i[k*LANE_W +: LANE_W];
            end
        end
    end

endmodule : mux8_4_sel
`default_nettype wire

// File: rtl/mux8_4.sv
`default_nettype none
// ============================================================================
//  Module      : mux8_4
//  Description : Registered lane multiplexer with valid qualifier.
//  Revision    : 1.0
// ============================================================================
module mux8_4
    import mux8_4_pkg::*;
#(
    parameter int LANE_W = C_LANE_W_DEF,
    parameter int LANES  = C_LANES_DEF,
    parameter int SEL_W  = sel_width(LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        select,
    input  logic [LANES*LANE_W-1:0] in,
    input  logic                    in_valid,
    output logic [LANE_W-1:0]       out,
    output logic                    out_valid
);

    logic [LANE_W-1:0] w_lane;
    logic [LANE_W-1:0] out_d;
    logic [LANE_W-1:0] out_q;
    logic              out_valid_q;

    mux8_4_sel #(
        .LANE_W (LANE_W),
        .LANES  (LANES),
        .SEL_W  (SEL_W)
    ) u_sel (
        .select_i (select),
        .in_i     (in),
        .lane_o   (w_lane)
    );

    always_comb begin
        out_d = out_q;
        if (in_valid) begin
            out_d = w_lane;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= in_valid;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule : mux8_4
`default_nettype wire

// File: tb/tb_mux8_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux8_4
//  Description : Self-checking bench for mux8_4 against a lane-arithmetic model.
//  Revision    : 1.0
// ============================================================================
module tb_mux8_4;

    logic        clk;
    logic        reset;
    logic [2:0]  select;
    logic [31:0] in;
    logic        in_valid;
    logic [3:0]  out;
    logic        out_valid;

    int checks;
    int errors;

    logic [3:0] exp_out;
    logic       exp_valid;
    bit         exp_known;

    mux8_4 dut (
        .clk       (clk),
        .reset     (reset),
        .select    (select),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, confirm no input reaches out before the
    // edge, then advance the model and compare after the edge.
    task automatic step(input logic r, input logic v, input logic [2:0] s,
                        input logic [31:0] d, input string tag);
        @(negedge clk);
        reset    = r;
        in_valid = v;
        select   = s;
        in       = d;
        #1;
        if (exp_known) begin
            chk({tag, "_pre_out"}, {28'd0, out}, {28'd0, exp_out});
            chk({tag, "_pre_vld"}, {31'd0, out_valid}, {31'd0, exp_valid});
        end
        @(posedge clk);
        if (r) begin
            exp_out   = 4'h0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = v;
            if (v) exp_out = 4'((d >> (4 * int'(s))) & 32'hF);
        end
        exp_known = 1'b1;
        #1;
        chk({tag, "_out"}, {28'd0, out}, {28'd0, exp_out});
        chk({tag, "_vld"}, {31'd0, out_valid}, {31'd0, exp_valid});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_out   = 4'h0;
        exp_valid = 1'b0;
        exp_known = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b1;
        select    = 3'd0;
        in        = 32'hFFFF_FFFF;

        // Reset with a live capture attempt on both edges.
        step(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, "reset0");
        step(1'b1, 1'b1, 3'd7, 32'hFFFF_FFFF, "reset1");

        // Sweep all lanes back to back.
        for (int s = 0; s < 8; s++) begin
            step(1'b0, 1'b1, 3'(s), 32'h7654_3210, $sformatf("sweep%0d", s));
        end

        // Hold when not qualified.
        step(1'b0, 1'b1, 3'd5, 32'h00A0_0000, "hold_cap");
        step(1'b0, 1'b0, 3'd5, 32'h0000_0000, "hold0");
        step(1'b0, 1'b0, 3'd2, 32'hFFFF_FFFF, "hold1");

        // Boundary lanes.
        step(1'b0, 1'b1, 3'd7, 32'hF000_000E, "bound7");
        step(1'b0, 1'b1, 3'd0, 32'hF000_000E, "bound0");

        // Unselected lanes must not matter.
        step(1'b0, 1'b1, 3'd4, 32'h0009_0000, "iso_a");
        step(1'b0, 1'b1, 3'd4, 32'hFFF9_FFFF, "iso_b");

        // Reset beats a simultaneous capture.
        step(1'b1, 1'b1, 3'd3, 32'h1234_5678, "prio_rst");
        step(1'b0, 1'b1, 3'd3, 32'h1234_5678, "prio_cap");

        // Mid-stream reset then idle: nothing residual.
        step(1'b0, 1'b1, 3'd6, 32'h0B00_0000, "mid_cap");
        step(1'b1, 1'b0, 3'd6, 32'h0B00_0000, "mid_rst");
        step(1'b0, 1'b0, 3'd6, 32'h0B00_0000, "mid_idle");

        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)),
                 32'($urandom),
                 "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule : tb_mux8_4
`default_nettype wire

// File: doc/mux8_4.md
MUX8_4 -- requirements
Module: mux8_4

Interface
REQ-001 Parameter LANE_W, default 4: width in bits of each input lane and of out.
REQ-002 Parameter LANES, default 8: number of input lanes; SEL_W = clog2(LANES), which is 3 at the defaults.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port select, input, SEL_W (3) bits: lane index, 0..7.
REQ-006 Port in, input, LANES*LANE_W (32) bits: packed lanes; lane k = in[LANE_W*k + LANE_W-1 : LANE_W*k], so lane 0 = in[3:0] and lane 7 = in[31:28].
REQ-007 Port in_valid, input, 1 bit: qualifies select and in for capture.
REQ-008 Port out, output, LANE_W (4) bits: registered selected lane.
REQ-009 Port out_valid, output, 1 bit: out holds a lane captured on the previous edge.

Function
REQ-010 On a rising clk edge with reset=0 and in_valid=1, out SHALL load lane[select] of in.
REQ-011 Latency SHALL be exactly one clock from the sampled select/in to out.
REQ-012 On a rising clk edge with reset=0 and in_valid=0, out SHALL hold its previous value.
REQ-013 out_valid SHALL be the value of in_valid registered on each non-reset edge; no backpressure exists.
REQ-014 All LANES values of select SHALL be legal, including boundary 0 (in[3:0]) and 7 (in[31:28]).
REQ-015 If LANES is not a power of two, any select >= LANES SHALL load all-zeros into out.
REQ-016 out SHALL depend only on the selected lane; changes in unselected lanes SHALL NOT affect out.
REQ-017 Changes in select or in between edges SHALL NOT affect out until the next qualifying edge; there is no combinational path from any input to out.
REQ-018 Back-to-back captures at 100% in_valid duty SHALL be supported, producing one result per clock.

Reset
REQ-019 When reset=1 at a rising edge, out SHALL become 0 and out_valid SHALL become 0.
REQ-020 Reset SHALL take priority over a simultaneous in_valid=1; that capture is discarded.
REQ-021 After reset deasserts, the first capture SHALL occur on the first edge with in_valid=1.
REQ-022 Reset asserted mid-stream SHALL clear both outputs on that edge, with no residual data afterwards.

Structure
REQ-023 LANE_W and LANES defaults and the SEL_W derivation SHALL live in a shared package, mux8_4_pkg.
REQ-024 Lane selection SHALL be a combinational sub-module, mux8_4_sel (select, in -> lane), followed by the output register in mux8_4.
REQ-025 The design SHALL contain no latches and exactly LANE_W+1 flip-flops.

Verification
REQ-026 Reset: assert reset 2 cycles with in_valid=1 and in=32'hFFFFFFFF -> out=4'h0, out_valid=0 on every reset edge.
REQ-027 Sweep: in=32'h76543210, in_valid=1, select=0..7 on consecutive cycles -> out=0,1,...,7, each one cycle after its select, with out_valid=1.
REQ-028 Hold: capture select=5 from in=32'h00A00000 (out=4'hA), then in_valid=0 with in changed to 0 -> out stays 4'hA and out_valid=0.
REQ-029 Boundary: in=32'hF000000E with select=7 -> out=4'hF; with select=0 -> out=4'hE.
REQ-030 Priority: reset=1 and in_valid=1 on the same edge with in=32'h12345678 and select=3 -> out=0 and out_valid=0; with reset=0 on the next edge -> out=4'h5.
REQ-031 Random: 1000 cycles of random in, select and in_valid checked against a one-cycle-delayed reference model -> zero mismatches.
